// File: rtl/adder_xbit_multicycle_ctrl.sv
// Multi-cycle wide adder: one shared CHUNK_WIDTH adder, LSB chunk first; ADDER_CTRL_SUB_EN adds i_sub (a-b).
// Latency: o_valid rises NUM_CHUNKS cycles after the accepting edge; issue interval NUM_CHUNKS+2.
// Backpressure: result held in DONE until i_ready; o_ready is a pure state decode (IDLE only).

module adder_xbit_serial #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module adder_xbit_multicycle_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
`ifdef ADDER_CTRL_SUB_EN
    input  logic                  i_sub,
`endif
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry,
    output logic                  o_busy
);
    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || NUM_CHUNKS < 1) begin : g_bad_cfg
        $error("adder_xbit_multicycle_ctrl: DATA_WIDTH must be a nonzero multiple of CHUNK_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   calc_step;
    logic [DATA_WIDTH-1:0]  a_reg;
    logic [DATA_WIDTH-1:0]  b_reg;
    logic [DATA_WIDTH-1:0]  res_reg;
    logic [DATA_WIDTH-1:0]  res_shift;
    logic [DATA_WIDTH-1:0]  b_load;
    logic                   carry_reg;
    logic                   carry_load;
    logic [CNT_W-1:0]       cnt;
    logic [CHUNK_WIDTH-1:0] sum_chunk;
    logic                   sum_cry;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b1;
        accept    = 1'b0;
        calc_step = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                calc_step = 1'b1;
                if (cnt == LAST_CHUNK) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtract is a + ~b + 1: invert b at capture and force the initial carry.
`ifdef ADDER_CTRL_SUB_EN
    assign b_load     = i_sub ? ~i_num_b : i_num_b;
    assign carry_load = i_sub | i_cry;
`else
    assign b_load     = i_num_b;
    assign carry_load = i_cry;
`endif

    adder_xbit_serial #(
        .WIDTH (CHUNK_WIDTH)
    ) u_chunk_adder (
        .a    (a_reg[CHUNK_WIDTH-1:0]),
        .b    (b_reg[CHUNK_WIDTH-1:0]),
        .cin  (carry_reg),
        .sum  (sum_chunk),
        .cout (sum_cry)
    );

    // Sum chunks enter at the MSB end so the LSB chunk lands at bit 0 after the last step.
    if (NUM_CHUNKS == 1) begin : g_single_chunk
        assign res_shift = sum_chunk;
    end else begin : g_multi_chunk
        assign res_shift = {sum_chunk, res_reg[DATA_WIDTH-1:CHUNK_WIDTH]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            a_reg     <= i_num_a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            cnt       <= '0;
        end else if (calc_step) begin
            a_reg     <= a_reg >> CHUNK_WIDTH;
            b_reg     <= b_reg >> CHUNK_WIDTH;
            res_reg   <= res_shift;
            carry_reg <= sum_cry;
            cnt       <= cnt + 1'b1;
        end
    end

    assign o_res = res_reg;
    assign o_cry = carry_reg;

endmodule

// File: tb/tb_adder_xbit_multicycle_ctrl.sv
// Bench for adder_xbit_multicycle_ctrl: instance 0 uses 8-bit chunks, instance 1 a single 32-bit chunk.
`timescale 1ns/1ps
module tb_adder_xbit_multicycle_ctrl;
    localparam int W = 32;
`ifdef ADDER_CTRL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n     [2];
    logic         valid_in  [2];
    logic         ready_out [2];
    logic [W-1:0] num_a     [2];
    logic [W-1:0] num_b     [2];
    logic         cry_in    [2];
    logic         sub_in    [2];
    logic         valid_out [2];
    logic         ready_in  [2];
    logic [W-1:0] res       [2];
    logic         cry_out   [2];
    logic         busy      [2];

    bit           rand_rdy  [2];
    bit           fixed_rdy [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        adder_xbit_multicycle_ctrl #(
            .DATA_WIDTH  (W),
            .CHUNK_WIDTH ((g == 0) ? 8 : 32)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n[g]),
            .i_valid (valid_in[g]),
            .o_ready (ready_out[g]),
            .i_num_a (num_a[g]),
            .i_num_b (num_b[g]),
            .i_cry   (cry_in[g]),
`ifdef ADDER_CTRL_SUB_EN
            .i_sub   (sub_in[g]),
`endif
            .o_valid (valid_out[g]),
            .i_ready (ready_in[g]),
            .o_res   (res[g]),
            .o_cry   (cry_out[g]),
            .o_busy  (busy[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            ready_in[k] = rand_rdy[k] ? ($urandom_range(0, 3) != 0) : fixed_rdy[k];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic; subtract gives a-b with carry meaning "no borrow".
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        if (SUB_EN && s) return {(a >= b), a - b};
        return 33'(a) + 33'(b) + 33'(c);
    endfunction

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    bit          busy_m  [2];
    logic [32:0] exp_m   [2];
    int          acc_cyc [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n[k] !== 1'b1) begin
                check("rst_valid", 64'(valid_out[k]), 64'd0);
                check("rst_busy", 64'(busy[k]), 64'd0);
                check("rst_res", 64'(res[k]), 64'd0);
                busy_m[k] = 1'b0;
            end else begin
                check("ready", 64'(ready_out[k]), 64'(!busy_m[k]));
                check("busy", 64'(busy[k]), 64'(busy_m[k]));
                check("valid", 64'(valid_out[k]),
                      64'(busy_m[k] && ((cyc - acc_cyc[k]) >= nch(k) + 1)));
                if (valid_out[k] && busy_m[k]) begin
                    check("result", 64'({cry_out[k], res[k]}), 64'(exp_m[k]));
                end
                if (valid_out[k] && ready_in[k]) begin
                    busy_m[k] = 1'b0;
                end else if (valid_in[k] && ready_out[k]) begin
                    busy_m[k]  = 1'b1;
                    exp_m[k]   = model(num_a[k], num_b[k], cry_in[k], sub_in[k]);
                    acc_cyc[k] = cyc;
                end
            end
        end
    end

    task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s);
        int n;
        @(posedge clk); #1;
        num_a[k] = a; num_b[k] = b; cry_in[k] = c; sub_in[k] = s;
        valid_in[k] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready_out[k]) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) check("send_timeout", 64'(ready_out[k]), 64'd1);
        @(posedge clk); #1;
        valid_in[k] = 1'b0;
        num_a[k] = $urandom;
        num_b[k] = $urandom;
        cry_in[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (valid_out[k]) begin
                lat = i - 1;
                break;
            end
        end
        if (lat < 0) check("valid_timeout", 64'(valid_out[k]), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_rand(input int k);
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(k, pick(), pick(), 1'($urandom_range(0, 1)),
                 SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; valid_in[k] = 1'b0; num_a[k] = '0; num_b[k] = '0;
            cry_in[k] = 1'b0; sub_in[k] = 1'b0; fixed_rdy[k] = 1'b1; rand_rdy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(ready_out[0]), 64'd1);
        check("post_rst_valid", 64'(valid_out[0]), 64'd0);
        check("post_rst_cry", 64'(cry_out[0]), 64'd0);

        // Carry out of the lowest chunk only.
        send(0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0);
        wait_valid(0, lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_res", 64'(res[0]), 64'h0000_0100);
        check("t1_cry", 64'(cry_out[0]), 64'd0);

        // Carry ripples through every chunk.
        send(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        wait_valid(0, lat);
        check("t2_res", 64'(res[0]), 64'h0);
        check("t2_cry", 64'(cry_out[0]), 64'd1);

        // Held result under backpressure with stray i_valid pulses.
        @(posedge clk); #1;
        fixed_rdy[0] = 1'b0;
        send(0, 32'h3, 32'h4, 1'b0, 1'b0);
        wait_valid(0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            valid_in[0] = 1'b1; num_a[0] = $urandom; num_b[0] = $urandom;
            @(negedge clk);
            check("t3_valid", 64'(valid_out[0]), 64'd1);
            check("t3_res", 64'(res[0]), 64'h7);
            check("t3_ready", 64'(ready_out[0]), 64'd0);
            check("t3_cry", 64'(cry_out[0]), 64'd0);
        end
        @(posedge clk); #1;
        valid_in[0] = 1'b0;
        fixed_rdy[0] = 1'b1;
        @(negedge clk);
        check("t3_valid_until_taken", 64'(valid_out[0]), 64'd1);
        @(negedge clk);
        check("t3_valid_drop", 64'(valid_out[0]), 64'd0);
        check("t3_ready_back", 64'(ready_out[0]), 64'd1);

        // Reset in the second CALC cycle aborts the operation.
        send(0, 32'h1, 32'h2, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        @(negedge clk);
        check("t4_rst_valid", 64'(valid_out[0]), 64'd0);
        check("t4_rst_res", 64'(res[0]), 64'd0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        @(negedge clk);
        check("t4_ready", 64'(ready_out[0]), 64'd1);
        check("t4_valid", 64'(valid_out[0]), 64'd0);
        send(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_valid(0, lat);
        check("t4_res", 64'(res[0]), 64'h2345_6789);
        check("t4_cry", 64'(cry_out[0]), 64'd0);

`ifdef ADDER_CTRL_SUB_EN
        send(0, 32'h5, 32'h7, 1'b0, 1'b1);
        wait_valid(0, lat);
        check("t5_borrow_res", 64'(res[0]), 64'hFFFF_FFFE);
        check("t5_borrow_cry", 64'(cry_out[0]), 64'd0);
        send(0, 32'h7, 32'h5, 1'b1, 1'b1);
        wait_valid(0, lat);
        check("t5_res", 64'(res[0]), 64'h2);
        check("t5_cry", 64'(cry_out[0]), 64'd1);
`endif

        // Single-chunk instance: one CALC cycle.
        send(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        wait_valid(1, lat);
        check("n1_latency", 64'(lat), 64'd1);
        check("n1_res", 64'(res[1]), 64'h0);
        check("n1_cry", 64'(cry_out[1]), 64'd1);

        rand_rdy[0] = 1'b1;
        rand_rdy[1] = 1'b1;
        fork
            run_rand(0);
            run_rand(1);
        join
        rand_rdy[0] = 1'b0;
        rand_rdy[1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("drain_busy0", 64'(busy[0]), 64'd0);
        check("drain_busy1", 64'(busy[1]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
